cfg_reg_wr_ctrl: RTL and testbench
==================================

CFG_REG_WR_CTRL -- requirements
Module: cfg_reg_wr_ctrl

Interface
REQ-001 Parameter DW, default 20, width of the controlled register vector and all data paths.
REQ-002 Parameter KEY, default 20'h51F15, unlock key value.
REQ-003 Parameter TMO, default 15, maximum cycles spent in UNLOCKED without a data write; range 1..255.
REQ-004 clk  in  1  single clock; all state is updated on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 bus_wr_valid  in  1  bus write request.
REQ-007 bus_wr_ready  out  1  bus write accepted this cycle when high together with bus_wr_valid.
REQ-008 bus_wr_sel  in  1  selects the bus write type: 0 = data write, 1 = key write.
REQ-009 bus_wr_data  in  DW  bus write payload.
REQ-010 hw_upd_valid  in  1  hardware update request; needs no key.
REQ-011 hw_upd_ready  out  1  hardware update accepted.
REQ-012 hw_upd_data  in  DW  hardware update payload.
REQ-013 reg_en  out  1  write enable to the async-reset register vector.
REQ-014 reg_d  out  DW  write data to the register vector.
REQ-015 cfg_unlocked  out  1  high while the FSM is in UNLOCKED.
REQ-016 bus_wr_err  out  1  one-cycle pulse on a rejected bus write.

Function
REQ-017 FSM states are LOCKED and UNLOCKED.
REQ-018 LOCKED -> UNLOCKED on an accepted key write with bus_wr_data == KEY.
REQ-019 UNLOCKED -> LOCKED on either of:
- an accepted bus data write;
- the timeout counter reaching TMO.
REQ-020 Any other accepted key write (wrong value, or any value while UNLOCKED) forces LOCKED and pulses bus_wr_err; it causes no register write.
REQ-021 A bus data write accepted in LOCKED pulses bus_wr_err and causes no register write.
REQ-022 Timeout counter:
- clears on entry to UNLOCKED;
- increments each cycle in UNLOCKED;
- saturates at 8 bits.
REQ-023 Key writes are always accepted: bus_wr_ready = 1 whenever bus_wr_sel = 1.
REQ-024 Register-targeting contenders are (a) a bus data write while UNLOCKED and (b) a hardware update.
REQ-025 With both contenders valid, grant alternates using a last-grant flag; a lone requester is granted immediately.
REQ-026 The last-grant flag resets to "bus", so hardware wins the first conflict.
REQ-027 A loser holds valid; its ready stays low until it is granted.
REQ-028 A bus data write while LOCKED does not contend; it is accepted at once and errors.
REQ-029 Output stage is registered, giving one-cycle latency:
- reg_en and reg_d are driven in the cycle after acceptance;
- back-to-back grants produce consecutive reg_en pulses.
REQ-030 While reg_en = 0, reg_d holds its last value.
REQ-031 A key write and a hardware update in the same cycle are both accepted; the FSM and the output stage update independently.
REQ-032 A bus data write and a timeout in the same cycle: the write wins if granted; if not granted it is re-evaluated next cycle in LOCKED and errors.

Reset
REQ-033 On rst_n low, all state resets asynchronously; after reset:
- FSM = LOCKED;
- counter = 0;
- reg_en = 0, reg_d = 0;
- cfg_unlocked = 0, bus_wr_err = 0;
- last-grant flag = bus.
REQ-034 Reset asserted mid-sequence discards any pending output-stage write and any unlock.
REQ-035 Reset release is synchronised externally; this block requires no internal synchroniser.

Structure
REQ-036 The FSM state encoding, the default KEY and the default TMO are held as constants in the shared AON/config package.
REQ-037 The grant logic is a separate sub-module, cfg_rr_arb2: a 2-input alternating arbiter with a last-grant register.
REQ-038 The register vector itself stays outside this block.

Verification
REQ-039 Key write 20'h51F15, then data write 20'h00ABC -> cfg_unlocked = 1 for exactly 1 cycle, reg_en pulse one cycle after the data acceptance with reg_d = 20'h00ABC, then LOCKED.
REQ-040 Data write 20'h12345 while LOCKED -> bus_wr_err pulse, no reg_en, state stays LOCKED.
REQ-041 Key write 20'h51F15, then 16 idle cycles with TMO = 15, then data write -> LOCKED after cycle 15, bus_wr_err on the data write, no reg_en.
REQ-042 After unlock, bus data 20'h00001 and hw data 20'h00002 both held valid over consecutive cycles -> first conflict grants hw (reg_d = 2), next cycle bus (reg_d = 1); two consecutive reg_en pulses.
REQ-043 Wrong key 20'h00000 -> bus_wr_err pulse, cfg_unlocked remains 0.
REQ-044 Unlock, then assert rst_n low in the same cycle as data acceptance -> no reg_en after release, FSM LOCKED, all outputs 0.

Source files
------------

// File: rtl/cfg_reg_wr_ctrl_pkg.sv
// Shared constants and types for the key-protected configuration write controller.
package cfg_reg_wr_ctrl_pkg;

    typedef enum logic {
        ST_LOCKED   = 1'b0,
        ST_UNLOCKED = 1'b1
    } cfg_state_t;

    localparam logic [19:0] CFG_DEF_KEY = 20'h51F15;
    localparam int          CFG_DEF_TMO = 15;
    localparam int          CFG_CNT_W   = 8;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CFG_CNT_W-1:0] sat_inc(input logic [CFG_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/cfg_rr_arb2.sv
// Two-input alternating arbiter. A lone requester wins at once; on a conflict
// the input that did not win last time is granted. The last-grant flag resets
// to input 0, so input 1 wins the first conflict.
module cfg_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_reg;   // 0: input 0 was granted last, 1: input 1

    // Grant selection from the current requests and the last winner.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_reg ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Remember who won whenever anything is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_reg <= 1'b0;
        end else if (|gnt) begin
            last_reg <= gnt[1];
        end
    end

endmodule

// File: rtl/cfg_reg_wr_ctrl.sv
// Key-protected write controller for an external configuration register
// vector. Bus data writes need a prior key write; hardware updates do not.
// Both share one registered write port through an alternating arbiter.
module cfg_reg_wr_ctrl
    import cfg_reg_wr_ctrl_pkg::*;
#(
    parameter int            DW  = 20,
    parameter logic [DW-1:0] KEY = DW'(CFG_DEF_KEY),
    parameter int            TMO = CFG_DEF_TMO
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          bus_wr_valid,
    output logic          bus_wr_ready,
    input  logic          bus_wr_sel,
    input  logic [DW-1:0] bus_wr_data,
    input  logic          hw_upd_valid,
    output logic          hw_upd_ready,
    input  logic [DW-1:0] hw_upd_data,
    output logic          reg_en,
    output logic [DW-1:0] reg_d,
    output logic          cfg_unlocked,
    output logic          bus_wr_err
);

    localparam logic [CFG_CNT_W-1:0] TMO_C = CFG_CNT_W'(TMO);

    cfg_state_t           state_reg;
    logic [CFG_CNT_W-1:0] cnt_reg;
    logic                 unlocked;
    logic                 key_wr;
    logic                 data_wr;
    logic                 timeout;
    logic [1:0]           req;
    logic [1:0]           gnt;

    assign unlocked = (state_reg == ST_UNLOCKED);
    assign key_wr   = bus_wr_valid &  bus_wr_sel;
    assign data_wr  = bus_wr_valid & ~bus_wr_sel;
    assign timeout  = (sat_inc(cnt_reg) >= TMO_C);

    // Only an unlocked bus data write contends for the register port;
    // a locked one is swallowed immediately and reported as an error.
    assign req = {hw_upd_valid, data_wr & unlocked};

    cfg_rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .gnt   (gnt)
    );

    assign bus_wr_ready = bus_wr_sel | ~unlocked | gnt[0];
    assign hw_upd_ready = gnt[1];
    assign cfg_unlocked = unlocked;

    // Lock/unlock FSM with its timeout counter and the error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_LOCKED;
            cnt_reg    <= '0;
            bus_wr_err <= 1'b0;
        end else begin
            bus_wr_err <= 1'b0;
            case (state_reg)
                ST_LOCKED: begin
                    cnt_reg <= '0;
                    if (key_wr) begin
                        if (bus_wr_data == KEY) begin
                            state_reg <= ST_UNLOCKED;
                        end else begin
                            bus_wr_err <= 1'b1;
                        end
                    end else if (data_wr) begin
                        bus_wr_err <= 1'b1;
                    end
                end
                ST_UNLOCKED: begin
                    cnt_reg <= sat_inc(cnt_reg);
                    if (key_wr) begin
                        // Any key write while open is treated as misuse.
                        state_reg  <= ST_LOCKED;
                        bus_wr_err <= 1'b1;
                    end else if (gnt[0] || timeout) begin
                        state_reg <= ST_LOCKED;
                    end
                end
                default: begin
                    state_reg <= ST_LOCKED;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    // Registered write port: one-cycle latency, data held while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_en <= 1'b0;
            reg_d  <= '0;
        end else begin
            reg_en <= |gnt;
            if (gnt[1]) begin
                reg_d <= hw_upd_data;
            end else if (gnt[0]) begin
                reg_d <= bus_wr_data;
            end
        end
    end

endmodule

// File: tb/tb_cfg_reg_wr_ctrl.sv
// Self-checking bench for cfg_reg_wr_ctrl: scenario tasks with inline checks
// plus a scoreboard of expected register writes checked by a monitor.
module tb_cfg_reg_wr_ctrl;

    localparam int          DW  = 20;
    localparam logic [19:0] KEY = 20'h51F15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          bus_wr_valid = 1'b0;
    logic          bus_wr_ready;
    logic          bus_wr_sel = 1'b0;
    logic [DW-1:0] bus_wr_data = '0;
    logic          hw_upd_valid = 1'b0;
    logic          hw_upd_ready;
    logic [DW-1:0] hw_upd_data = '0;
    logic          reg_en;
    logic [DW-1:0] reg_d;
    logic          cfg_unlocked;
    logic          bus_wr_err;

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] exp_q[$];

    cfg_reg_wr_ctrl #(.DW(DW), .KEY(KEY), .TMO(15)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus_wr_valid (bus_wr_valid),
        .bus_wr_ready (bus_wr_ready),
        .bus_wr_sel   (bus_wr_sel),
        .bus_wr_data  (bus_wr_data),
        .hw_upd_valid (hw_upd_valid),
        .hw_upd_ready (hw_upd_ready),
        .hw_upd_data  (hw_upd_data),
        .reg_en       (reg_en),
        .reg_d        (reg_d),
        .cfg_unlocked (cfg_unlocked),
        .bus_wr_err   (bus_wr_err)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every reg_en pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (reg_en === 1'b1) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL sb_unexpected: reg_en=1 reg_d=%h, required no write", reg_d);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (reg_d !== e) begin
                    errors = errors + 1;
                    $display("FAIL sb_data: reg_d=%h required=%h", reg_d, e);
                end else begin
                    $display("write ok: reg_d=%h", reg_d);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_wr_valid = 1'b0;
        bus_wr_sel   = 1'b0;
        bus_wr_data  = '0;
        hw_upd_valid = 1'b0;
        hw_upd_data  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] req_v);
        checks = checks + 1;
        if (got !== req_v) begin
            errors = errors + 1;
            $display("FAIL %s: got=%h required=%h", name, got, req_v);
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        chk("rst_reg_en", DW'(reg_en), DW'(1'b0));
        chk("rst_reg_d", reg_d, '0);
        chk("rst_unlocked", DW'(cfg_unlocked), DW'(1'b0));
        chk("rst_err", DW'(bus_wr_err), DW'(1'b0));
        chk("rst_bus_ready", DW'(bus_wr_ready), DW'(1'b1));
        $display("test_reset done");
    endtask

    task automatic key_write(input logic [DW-1:0] k);
        bus_wr_valid = 1'b1;
        bus_wr_sel   = 1'b1;
        bus_wr_data  = k;
        #1;
        chk("key_ready", DW'(bus_wr_ready), DW'(1'b1));
        step();
        idle_inputs();
    endtask

    task automatic test_unlock_write();
        key_write(KEY);
        chk("ul_unlocked", DW'(cfg_unlocked), DW'(1'b1));
        bus_wr_valid = 1'b1;
        bus_wr_sel   = 1'b0;
        bus_wr_data  = 20'h00ABC;
        #1;
        chk("ul_data_ready", DW'(bus_wr_ready), DW'(1'b1));
        exp_q.push_back(20'h00ABC);
        step();
        idle_inputs();
        chk("ul_relocked", DW'(cfg_unlocked), DW'(1'b0));
        chk("ul_reg_en", DW'(reg_en), DW'(1'b1));
        chk("ul_err", DW'(bus_wr_err), DW'(1'b0));
        step();
        chk("ul_en_drop", DW'(reg_en), DW'(1'b0));
        chk("ul_d_hold", reg_d, 20'h00ABC);
        $display("test_unlock_write done");
    endtask

    task automatic test_locked_write();
        bus_wr_valid = 1'b1;
        bus_wr_sel   = 1'b0;
        bus_wr_data  = 20'h12345;
        #1;
        chk("lw_ready", DW'(bus_wr_ready), DW'(1'b1));
        step();
        idle_inputs();
        chk("lw_err", DW'(bus_wr_err), DW'(1'b1));
        chk("lw_reg_en", DW'(reg_en), DW'(1'b0));
        chk("lw_unlocked", DW'(cfg_unlocked), DW'(1'b0));
        step();
        chk("lw_err_pulse", DW'(bus_wr_err), DW'(1'b0));
        $display("test_locked_write done");
    endtask

    task automatic test_timeout();
        key_write(KEY);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("tmo_unlocked_%0d", i), DW'(cfg_unlocked), DW'(i < 15));
            step();
        end
        bus_wr_valid = 1'b1;
        bus_wr_sel   = 1'b0;
        bus_wr_data  = 20'h00777;
        step();
        idle_inputs();
        chk("tmo_err", DW'(bus_wr_err), DW'(1'b1));
        chk("tmo_reg_en", DW'(reg_en), DW'(1'b0));
        $display("test_timeout done");
    endtask

    task automatic test_arbitration();
        do_reset();
        key_write(KEY);
        bus_wr_valid = 1'b1;
        bus_wr_sel   = 1'b0;
        bus_wr_data  = 20'h00001;
        hw_upd_valid = 1'b1;
        hw_upd_data  = 20'h00002;
        #1;
        chk("arb1_hw_ready", DW'(hw_upd_ready), DW'(1'b1));
        chk("arb1_bus_ready", DW'(bus_wr_ready), DW'(1'b0));
        exp_q.push_back(20'h00002);
        step();
        hw_upd_valid = 1'b0;
        chk("arb1_reg_en", DW'(reg_en), DW'(1'b1));
        chk("arb1_still_unlocked", DW'(cfg_unlocked), DW'(1'b1));
        #1;
        chk("arb2_bus_ready", DW'(bus_wr_ready), DW'(1'b1));
        exp_q.push_back(20'h00001);
        step();
        idle_inputs();
        chk("arb2_reg_en", DW'(reg_en), DW'(1'b1));
        chk("arb2_locked", DW'(cfg_unlocked), DW'(1'b0));
        step();
        chk("arb3_reg_en", DW'(reg_en), DW'(1'b0));
        chk("arb3_d_hold", reg_d, 20'h00001);
        $display("test_arbitration done");
    endtask

    task automatic test_wrong_key();
        key_write(20'h00000);
        chk("wk_err", DW'(bus_wr_err), DW'(1'b1));
        chk("wk_unlocked", DW'(cfg_unlocked), DW'(1'b0));
        $display("test_wrong_key done");
    endtask

    task automatic test_key_with_hw();
        bus_wr_valid = 1'b1;
        bus_wr_sel   = 1'b1;
        bus_wr_data  = KEY;
        hw_upd_valid = 1'b1;
        hw_upd_data  = 20'h3C3C3;
        #1;
        chk("kh_bus_ready", DW'(bus_wr_ready), DW'(1'b1));
        chk("kh_hw_ready", DW'(hw_upd_ready), DW'(1'b1));
        exp_q.push_back(20'h3C3C3);
        step();
        idle_inputs();
        chk("kh_unlocked", DW'(cfg_unlocked), DW'(1'b1));
        chk("kh_reg_en", DW'(reg_en), DW'(1'b1));
        // A second key write while open must relock and error.
        key_write(KEY);
        chk("kh_rekey_err", DW'(bus_wr_err), DW'(1'b1));
        chk("kh_rekey_locked", DW'(cfg_unlocked), DW'(1'b0));
        chk("kh_rekey_no_en", DW'(reg_en), DW'(1'b0));
        $display("test_key_with_hw done");
    endtask

    task automatic test_reset_mid();
        key_write(KEY);
        bus_wr_valid = 1'b1;
        bus_wr_sel   = 1'b0;
        bus_wr_data  = 20'h0F0F0;
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        idle_inputs();
        rst_n = 1'b1;
        step();
        chk("rm_reg_en", DW'(reg_en), DW'(1'b0));
        chk("rm_reg_d", reg_d, '0);
        chk("rm_unlocked", DW'(cfg_unlocked), DW'(1'b0));
        chk("rm_err", DW'(bus_wr_err), DW'(1'b0));
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_unlock_write();
        test_locked_write();
        test_timeout();
        test_arbitration();
        test_wrong_key();
        test_key_with_hw();
        test_reset_mid();
        step();
        chk("sb_drained", DW'(exp_q.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
